// File: rtl/chdr_16sc_to_32f_pkg.sv
// Shared definitions for the CHDR sc16 <-> fc32 converters: state encodings,
// CHDR header bit positions and header-line byte counts.
package chdr_16sc_to_32f_pkg;

  typedef enum logic [1:0] {
    ST_HEADER = 2'd0,
    ST_TIME   = 2'd1,
    ST_FIRST  = 2'd2,
    ST_SECOND = 2'd3
  } chdr_state_t;

  localparam int unsigned HAS_TIME_BIT = 61;
  localparam int unsigned LEN_MSB      = 47;
  localparam int unsigned LEN_LSB      = 32;

  localparam logic [15:0] HDR_BYTES      = 16'd8;
  localparam logic [15:0] HDR_TIME_BYTES = 16'd16;

endpackage

// File: rtl/chdr_16sc_to_32f_iq_to_float.sv
// Exact conversion of a signed fixed-point component (value = x * 2^-(BITS_IN-1))
// to an IEEE-754 single-precision word. Purely combinational.
module iq_to_float #(
  parameter int unsigned BITS_IN  = 16,
  parameter int unsigned BITS_OUT = 32
) (
  input  logic [BITS_IN-1:0]  iq_in,
  output logic [BITS_OUT-1:0] f_out
);

  localparam int unsigned MANT_W   = 23;
  localparam int unsigned EXP_BIAS = 127;
  localparam int unsigned LW       = $clog2(BITS_IN);

  logic               sign;
  logic [BITS_IN-1:0] mag;
  logic [BITS_IN-1:0] norm;
  logic [LW-1:0]      lead;
  logic [LW-1:0]      shift;
  logic [7:0]         expo;
  logic [MANT_W-1:0]  mant;
  logic               unused_hidden;

  assign sign = iq_in[BITS_IN-1];
  // Most-negative input negates to 2^(BITS_IN-1), which still fits unsigned.
  assign mag  = sign ? (~iq_in + 1'b1) : iq_in;

  always_comb begin
    lead = '0;
    for (int unsigned i = 0; i < BITS_IN; i++) begin
      if (mag[i]) lead = LW'(i);
    end
  end

  assign shift         = LW'(BITS_IN - 1) - lead;
  assign norm          = mag << shift;
  assign unused_hidden = norm[BITS_IN-1];
  assign expo          = 8'(EXP_BIAS - (BITS_IN - 1)) + 8'(lead);
  assign mant          = {norm[BITS_IN-2:0], {(MANT_W - BITS_IN + 1){1'b0}}};
  assign f_out         = (mag == '0) ? '0 : BITS_OUT'({sign, expo, mant});

endmodule

// File: rtl/chdr_16sc_to_32f.sv
// Streaming CHDR converter: each sc16 payload line (two samples) becomes two fc32
// lines; header length is rewritten and the SID destination optionally replaced.
module chdr_16sc_to_32f
  import chdr_16sc_to_32f_pkg::*;
#(
  parameter logic [7:0] BASE = 8'd0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        set_stb,
  input  logic [7:0]  set_addr,
  input  logic [31:0] set_data,
  input  logic [63:0] i_tdata,
  input  logic        i_tlast,
  input  logic        i_tvalid,
  output logic        i_tready,
  output logic [63:0] o_tdata,
  output logic        o_tlast,
  output logic        o_tvalid,
  input  logic        o_tready,
  output logic [31:0] debug
);

  chdr_state_t state;
  logic        half;
  logic [15:0] pkt_count;
  logic        sid_en;
  logic [15:0] new_dst;

  logic [15:0] hdr_len;
  logic [15:0] payload_len;
  logic [15:0] len_out;
  logic        has_time;
  logic        single;
  logic        xfer;
  logic [31:0] sample;
  logic [31:0] f_imag;
  logic [31:0] f_real;
  logic        unused_bits;

  assign has_time    = i_tdata[HAS_TIME_BIT];
  assign hdr_len     = has_time ? HDR_TIME_BYTES : HDR_BYTES;
  assign payload_len = i_tdata[LEN_MSB:LEN_LSB] - hdr_len;
  // Whole samples only: 4 input bytes per sample become 8 output bytes.
  assign len_out     = hdr_len + {payload_len[14:2], 3'b000};
  assign single      = i_tlast && half;
  assign xfer        = o_tvalid && o_tready;
  assign unused_bits = ^{set_data[31:17], payload_len[15], payload_len[1:0]};

  assign sample = (state == ST_SECOND) ? i_tdata[31:0] : i_tdata[63:32];

  iq_to_float #(.BITS_IN(16), .BITS_OUT(32)) u_imag (
    .iq_in (sample[31:16]),
    .f_out (f_imag)
  );

  iq_to_float #(.BITS_IN(16), .BITS_OUT(32)) u_real (
    .iq_in (sample[15:0]),
    .f_out (f_real)
  );

  always_comb begin
    o_tdata  = i_tdata;
    o_tlast  = i_tlast;
    o_tvalid = i_tvalid;
    i_tready = o_tready;
    case (state)
      ST_HEADER: o_tdata = {i_tdata[63:48], len_out,
                            sid_en ? {i_tdata[15:0], new_dst} : i_tdata[31:0]};
      ST_TIME:   o_tdata = i_tdata;
      ST_FIRST: begin
        o_tdata = {f_imag, f_real};
        // Hold the input line so its second sample is still present next beat.
        if (!single) begin
          i_tready = 1'b0;
          o_tlast  = 1'b0;
        end
      end
      ST_SECOND: o_tdata = {f_imag, f_real};
      default:   o_tdata = i_tdata;
    endcase
    if (!reset_n) begin
      o_tvalid = 1'b0;
      i_tready = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sid_en  <= 1'b0;
      new_dst <= '0;
    end else if (set_stb && (set_addr == BASE)) begin
      sid_en  <= set_data[16];
      new_dst <= set_data[15:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_HEADER;
      half      <= 1'b0;
      pkt_count <= '0;
    end else if (xfer) begin
      if (o_tlast) pkt_count <= pkt_count + 16'd1;
      case (state)
        ST_HEADER: begin
          half <= payload_len[2];
          if (i_tlast)       state <= ST_HEADER;
          else if (has_time) state <= ST_TIME;
          else               state <= ST_FIRST;
        end
        ST_TIME:   state <= i_tlast ? ST_HEADER : ST_FIRST;
        ST_FIRST:  state <= single  ? ST_HEADER : ST_SECOND;
        ST_SECOND: state <= i_tlast ? ST_HEADER : ST_FIRST;
        default:   state <= ST_HEADER;
      endcase
    end
  end

  assign debug = {state, half, 13'b0, pkt_count};

endmodule

// File: tb/tb_chdr_16sc_to_32f.sv
// Directed and backpressured stimulus for chdr_16sc_to_32f with an independent
// fc32 reference built from the simulator's double-precision representation.
module tb_chdr_16sc_to_32f;

  localparam logic [7:0] TB_BASE = 8'h20;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        set_stb;
  logic [7:0]  set_addr;
  logic [31:0] set_data;
  logic [63:0] i_tdata;
  logic        i_tlast;
  logic        i_tvalid;
  logic        i_tready;
  logic [63:0] o_tdata;
  logic        o_tlast;
  logic        o_tvalid;
  logic        o_tready;
  logic [31:0] debug;

  chdr_16sc_to_32f #(.BASE(TB_BASE)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .set_stb  (set_stb),
    .set_addr (set_addr),
    .set_data (set_data),
    .i_tdata  (i_tdata),
    .i_tlast  (i_tlast),
    .i_tvalid (i_tvalid),
    .i_tready (i_tready),
    .o_tdata  (o_tdata),
    .o_tlast  (o_tlast),
    .o_tvalid (o_tvalid),
    .o_tready (o_tready),
    .debug    (debug)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic        last;
  } beat_t;

  beat_t in_q[$];
  beat_t exp_q[$];

  int checks   = 0;
  int failures = 0;

  logic        m_sid_en  = 1'b0;
  logic [15:0] m_new_dst = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] to_f32(input logic [15:0] v);
    real         r;
    logic [63:0] d;
    logic [10:0] e;
    if (v == 16'h0000) return 32'h0;
    r = real'($signed(v)) / 32768.0;
    d = $realtobits(r);
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic beat_t mk(input logic [63:0] d, input logic l);
    beat_t b;
    b.data = d;
    b.last = l;
    return b;
  endfunction

  task automatic add_pkt(input bit ht, input int ns, input logic [31:0] sid);
    logic [15:0] hlen;
    logic [15:0] flags;
    logic [31:0] s[$];
    logic [31:0] osid;
    logic [63:0] t;
    hlen  = ht ? 16'd16 : 16'd8;
    flags = ht ? 16'h2000 : 16'h0000;
    osid  = m_sid_en ? {sid[15:0], m_new_dst} : sid;
    in_q.push_back(mk({flags, hlen + 16'(4 * ns), sid}, (ns == 0) && !ht));
    exp_q.push_back(mk({flags, hlen + 16'(8 * ns), osid}, (ns == 0) && !ht));
    if (ht) begin
      t = {$urandom(), $urandom()};
      in_q.push_back(mk(t, ns == 0));
      exp_q.push_back(mk(t, ns == 0));
    end
    for (int i = 0; i < ns; i++) s.push_back($urandom());
    for (int i = 0; i < ns; i += 2) begin
      in_q.push_back(mk({s[i], (i + 1 < ns) ? s[i+1] : $urandom()}, i + 2 >= ns));
      exp_q.push_back(mk({to_f32(s[i][31:16]), to_f32(s[i][15:0])}, i + 1 == ns));
      if (i + 1 < ns)
        exp_q.push_back(mk({to_f32(s[i+1][31:16]), to_f32(s[i+1][15:0])}, i + 2 == ns));
    end
  endtask

  // Drives in_q, scores outputs against exp_q; entered and left just after a posedge.
  task automatic run(input int max_cycles, input bit random_bp);
    int    cyc = 0;
    int    idx = 0;
    int    n_in;
    beat_t e;
    n_in = in_q.size();
    while ((idx < n_in || exp_q.size() > 0) && cyc < max_cycles) begin
      i_tvalid = (idx < n_in);
      i_tdata  = (idx < n_in) ? in_q[idx].data : 64'h0;
      i_tlast  = (idx < n_in) ? in_q[idx].last : 1'b0;
      o_tready = random_bp ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(negedge clk);
      if (o_tvalid && o_tready) begin
        if (exp_q.size() == 0) begin
          check("extra_beat", o_tdata, 64'h0);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", o_tdata, e.data);
          check("beat_last", {63'h0, o_tlast}, {63'h0, e.last});
        end
      end
      if (i_tvalid && i_tready) idx++;
      @(posedge clk);
      #1;
      cyc++;
    end
    check("exp_drained", 64'(exp_q.size()), 64'h0);
    check("in_xfers", 64'(idx), 64'(n_in));
    i_tvalid = 1'b0;
    i_tlast  = 1'b0;
    o_tready = 1'b1;
    in_q.delete();
    exp_q.delete();
  endtask

  task automatic write_set(input logic [7:0] a, input logic [31:0] d);
    set_stb  = 1'b1;
    set_addr = a;
    set_data = d;
    @(posedge clk);
    #1;
    set_stb = 1'b0;
    if (a == TB_BASE) begin
      m_sid_en  = d[16];
      m_new_dst = d[15:0];
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n   = 1'b1;
    m_sid_en  = 1'b0;
    m_new_dst = '0;
  endtask

  initial begin
    reset_n  = 1'b0;
    set_stb  = 1'b0;
    set_addr = '0;
    set_data = '0;
    i_tdata  = 64'h0000_0008_0000_0000;
    i_tlast  = 1'b1;
    i_tvalid = 1'b1;
    o_tready = 1'b1;
    #3;
    check("rst_o_tvalid", {63'h0, o_tvalid}, 64'h0);
    check("rst_i_tready", {63'h0, i_tready}, 64'h0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_debug", {32'h0, debug}, 64'h0);
    i_tvalid = 1'b0;
    i_tlast  = 1'b0;
    reset_n  = 1'b1;

    // Plain packet: four samples including full-scale and LSB values.
    in_q.push_back(mk(64'h0000_0018_0001_0002, 1'b0));
    in_q.push_back(mk(64'h4000_8000_0001_FFFF, 1'b0));
    in_q.push_back(mk(64'h7FFF_0000_C000_0000, 1'b1));
    exp_q.push_back(mk(64'h0000_0028_0001_0002, 1'b0));
    exp_q.push_back(mk(64'h3F000000_BF800000, 1'b0));
    exp_q.push_back(mk(64'h38000000_B8000000, 1'b0));
    exp_q.push_back(mk(64'h3F7FFE00_00000000, 1'b0));
    exp_q.push_back(mk(64'hBF000000_00000000, 1'b1));
    run(100, 1'b0);
    check("pkt_count_1", {48'h0, debug[15:0]}, 64'd1);

    // Timed packet with a single sample: one output payload line.
    in_q.push_back(mk(64'h2000_0014_0000_0001, 1'b0));
    in_q.push_back(mk(64'h1122_3344_5566_7788, 1'b0));
    in_q.push_back(mk(64'h4000_4000_DEAD_BEEF, 1'b1));
    exp_q.push_back(mk(64'h2000_0018_0000_0001, 1'b0));
    exp_q.push_back(mk(64'h1122_3344_5566_7788, 1'b0));
    exp_q.push_back(mk(64'h3F000000_3F000000, 1'b1));
    run(100, 1'b0);
    check("half_cleared_state", {62'h0, debug[31:30]}, 64'd0);

    // SID rewrite, wrong-address write ignored, then disable.
    write_set(TB_BASE, 32'h0001_ABCD);
    in_q.push_back(mk(64'h0000_0008_1234_5678, 1'b1));
    exp_q.push_back(mk(64'h0000_0008_5678_ABCD, 1'b1));
    run(50, 1'b0);
    check("hdr_only_state", {62'h0, debug[31:30]}, 64'd0);
    write_set(TB_BASE, 32'h0);
    write_set(TB_BASE + 8'd1, 32'h0001_FFFF);
    in_q.push_back(mk(64'h0000_0008_1234_5678, 1'b1));
    exp_q.push_back(mk(64'h0000_0008_1234_5678, 1'b1));
    run(50, 1'b0);
    check("pkt_count_4", {48'h0, debug[15:0]}, 64'd4);

    // 100 random packets under random backpressure.
    do_reset();
    for (int p = 0; p < 100; p++)
      add_pkt($urandom_range(0, 1) == 1, $urandom_range(1, 64), $urandom());
    run(60000, 1'b1);
    check("pkt_count_100", {48'h0, debug[15:0]}, 64'd100);

    // Reset asserted while in SECOND.
    i_tvalid = 1'b1;
    i_tdata  = 64'h0000_0010_0000_0000;
    i_tlast  = 1'b0;
    o_tready = 1'b1;
    @(posedge clk);
    #1;
    i_tdata = 64'h4000_4000_4000_4000;
    i_tlast = 1'b1;
    @(posedge clk);
    #1;
    check("in_second", {62'h0, debug[31:30]}, 64'd3);
    reset_n = 1'b0;
    #1;
    check("mid_rst_o_tvalid", {63'h0, o_tvalid}, 64'h0);
    check("mid_rst_i_tready", {63'h0, i_tready}, 64'h0);
    i_tvalid = 1'b0;
    i_tlast  = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    check("post_rst_debug", {32'h0, debug}, 64'h0);
    in_q.push_back(mk(64'h0000_0010_CAFE_F00D, 1'b1));
    exp_q.push_back(mk(64'h0000_0018_CAFE_F00D, 1'b1));
    run(50, 1'b0);
    check("post_rst_count", {48'h0, debug[15:0]}, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
